demux_1to4_reg: RTL and testbench

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

---
 rtl/demux_pkg.sv | 17 +
 rtl/out_slot.sv | 39 +++
 rtl/demux_1to4_reg.sv | 60 ++++++
 tb/tb_demux_1to4_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 registered demux: channel count, select/counter widths, slot encoding.
// The pop counters exist only when DEMUX_1TO4_STATS_EN is defined.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output register slot with valid/ready handshake.
// Latency: a write is visible as rd_vld/rd_dat one cycle later.
// Backpressure: the owner writes only when the slot is empty or is being popped.
module out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat
);

  logic [0:0]       state;
  logic [WIDTH-1:0] data_q;
  logic             pop;

  assign rd_vld = (state == FULL);
  assign rd_dat = data_q;
  assign pop    = rd_vld & rd_rdy;

  // A write wins over a pop, so a pop and a write in the same cycle leave the slot full with new data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      data_q <= '0;
    end else if (wr_vld) begin
      state  <= FULL;
      data_q <= wr_dat;
    end else if (pop) begin
      state  <= EMPTY;
    end
  end

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux. Each channel has its own one-entry slot. Latency is one cycle.
// A full channel stalls only words addressed to it. DEMUX_1TO4_STATS_EN adds saturating per-channel pop counters.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [SEL_W-1:0]        in_sel_i,
  input  logic [WIDTH-1:0]        in_data_i,
  output logic [NUM_CH-1:0]       out_valid_o,
  input  logic [NUM_CH-1:0]       out_ready_i,
  output logic [NUM_CH*WIDTH-1:0] out_data_o,
  output logic [NUM_CH*CNT_W-1:0] stat_cnt_o
);

  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] wr_en;
  logic              accept;

  // The ready path is combinational through the target slot's pop, so there is no bubble on back-to-back words.
  assign in_ready_o = !rst_i && (!out_valid_o[in_sel_i] || out_ready_i[in_sel_i]);
  assign accept     = in_valid_i && in_ready_o;
  assign sel_oh     = {{(NUM_CH-1){1'b0}}, 1'b1} << in_sel_i;
  assign wr_en      = accept ? sel_oh : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_vld (wr_en[k]),
      .wr_dat (in_data_i),
      .rd_rdy (out_ready_i[k]),
      .rd_vld (out_valid_o[k]),
      .rd_dat (out_data_o[k*WIDTH +: WIDTH])
    );
  end

`ifdef DEMUX_1TO4_STATS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (out_valid_o[k] && out_ready_i[k]) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end

    assign stat_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed, table-driven bench for demux_1to4_reg, plus hand-written sequences for pop counting and reset.
// The expected counter values follow DEMUX_1TO4_STATS_EN.
module tb_demux_1to4_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  in_sel_i;
  logic [7:0]  in_data_i;
  logic [3:0]  out_valid_o;
  logic [3:0]  out_ready_i;
  logic [31:0] out_data_o;
  logic [31:0] stat_cnt_o;

  int errors = 0;
  int checks = 0;

  demux_1to4_reg #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_sel_i    (in_sel_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .stat_cnt_o  (stat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        exp_rdy;   // in_ready_o before the edge
    logic [3:0]  exp_ov;    // out_valid_o after the edge
    int          ch;        // channel whose data is checked after the edge
    logic [7:0]  exp_dat;
    logic [31:0] exp_stat;  // stat_cnt_o after the edge when counters are built
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef DEMUX_1TO4_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  vec_t vt [10];

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_sel_i    = 2'd0;
    in_data_i   = 8'h00;
    out_ready_i = 4'b0000;

    //           rst   iv    sel   dat    ordy     rdy   ov       ch dat    stat
    vt[0] = '{1'b1, 1'b1, 2'd3, 8'hFF, 4'b0000, 1'b0, 4'b0000, 3, 8'h00, 32'h00000000};
    vt[1] = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2, 8'hA5, 32'h00000000};
    vt[2] = '{1'b0, 1'b1, 2'd2, 8'h3C, 4'b0000, 1'b0, 4'b0100, 2, 8'hA5, 32'h00000000};
    vt[3] = '{1'b0, 1'b1, 2'd1, 8'h5A, 4'b0000, 1'b1, 4'b0110, 1, 8'h5A, 32'h00000000};
    vt[4] = '{1'b0, 1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0111, 0, 8'h11, 32'h00000000};
    vt[5] = '{1'b0, 1'b1, 2'd0, 8'h22, 4'b0001, 1'b1, 4'b0111, 0, 8'h22, 32'h00000001};
    vt[6] = '{1'b0, 1'b1, 2'd3, 8'h77, 4'b0000, 1'b1, 4'b1111, 3, 8'h77, 32'h00000001};
    vt[7] = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b1111, 1'b1, 4'b0000, 2, 8'hA5, 32'h01010102};
    vt[8] = '{1'b0, 1'b1, 2'd3, 8'hC3, 4'b0000, 1'b1, 4'b1000, 3, 8'hC3, 32'h01010102};
    vt[9] = '{1'b1, 1'b1, 2'd1, 8'h99, 4'b0000, 1'b0, 4'b0000, 1, 8'h00, 32'h00000000};

    @(posedge clk_i);
    #1;
    for (int i = 0; i < 10; i++) begin
      rst_i       = vt[i].rst;
      in_valid_i  = vt[i].iv;
      in_sel_i    = vt[i].sel;
      in_data_i   = vt[i].dat;
      out_ready_i = vt[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready_o}, {31'd0, vt[i].exp_rdy});
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d out_valid", i), {28'd0, out_valid_o}, {28'd0, vt[i].exp_ov});
      chk($sformatf("v%0d data_ch%0d", i, vt[i].ch), {24'd0, out_data_o[vt[i].ch*8 +: 8]}, {24'd0, vt[i].exp_dat});
      chk($sformatf("v%0d stat", i), stat_cnt_o, stat_exp(vt[i].exp_stat));
    end
    chk("reset_all_data", out_data_o, 32'h0);

    // Stream 301 words into channel 1 with its consumer always ready: the first is only accepted, the next 300 also pop.
    rst_i       = 1'b0;
    in_valid_i  = 1'b1;
    in_sel_i    = 2'd1;
    out_ready_i = 4'b0010;
    begin
      int stalls = 0;
      for (int i = 0; i < 301; i++) begin
        in_data_i = 8'(i);
        #1;
        if (!in_ready_o) stalls++;
        @(posedge clk_i);
        #1;
        if (i == 100) chk("stat_after_100_pops", stat_cnt_o, stat_exp(32'h00006400));
      end
      chk("stream_no_stall", stalls, 0);
    end
    chk("stream_last_data", {24'd0, out_data_o[15:8]}, 32'h0000002C);
    chk("stat_saturated", stat_cnt_o, stat_exp(32'h0000FF00));

    // Reset while channel 1 is full and being popped must clear it without counting a pop.
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("mid_reset_valid", {28'd0, out_valid_o}, 32'h0);
    chk("mid_reset_stat", stat_cnt_o, 32'h0);
    rst_i       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 4'b0000;
    @(posedge clk_i);
    #1;
    chk("idle_after_reset", {28'd0, out_valid_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
